// File: rtl/fetch_queue_pkg.sv
// Shared processor package for the instruction fetch front end.
// Holds the fetch FSM state encoding, the default reset fetch address,
// the queue entry width and the word-address increment helper.
// No ports (package).
package fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request outstanding
    WAIT  = 2'd1,  // request outstanding, response will be queued
    DRAIN = 2'd2   // request outstanding, response will be discarded
  } fetchState_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  // One queue entry: {instruction word, fetch address + 1}
  localparam int ENTRY_W = 64;

  // Word-based addressing, wraps modulo 2^32.
  function automatic word_t nextPc(input word_t pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle of the fetch queue.
// Instruction memory side: imem_req, imem_addr (queue -> memory),
//   imem_ready, imem_rdata (memory -> queue).
// Pipeline side: stall, redirect, redirect_pc (ID/hazard -> queue),
//   instr_out, pc_plus_one_out, instr_valid (queue -> IF/ID register).
// master = the fetch queue, slave = memory plus decode stage.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_rdata;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  word_t instr_out;
  word_t pc_plus_one_out;
  logic  instr_valid;

  modport master (
    output imem_req, imem_addr, instr_out, pc_plus_one_out, instr_valid,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_plus_one_out, instr_valid,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: DEPTH entries of ENTRY_W bits.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   push,pushData write one entry at the tail
//   pop           drop the head entry
//   flush         empty the queue; wins over push and pop
//   headData      entry at the head (straight from storage)
//   count         number of valid entries, 0..DEPTH
// The caller never pushes when full nor pops when empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(push);
      rdPtr <= rdPtr + PTR_W'(pop);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue.
// Issues one word-addressed fetch at a time to instruction memory, queues
// responses together with their address+1, and presents the head entry to
// the IF/ID register. A redirect flushes the queue and restarts fetching
// at redirect_pc; a response still in flight at that point is discarded.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fetch_queue_if.master (memory handshake + pipeline side)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetchState_t        state;
  fetchState_t        stateNext;
  word_t              fetchPc;
  word_t              fetchPcNext;
  word_t              reqAddr;
  word_t              reqAddrNext;
  logic               push;
  logic               pop;
  logic               flush;
  logic               instrValid;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     countAfter;
  logic [ENTRY_W-1:0] headData;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({bus.imem_rdata, nextPc(reqAddr)}),
    .pop      (pop),
    .flush    (flush),
    .headData (headData),
    .count    (count)
  );

  assign instrValid = (count != '0);

  // A redirect empties the queue, so the head is not consumed that cycle.
  assign pop = instrValid && !bus.stall && !bus.redirect;

  // Occupancy after this cycle's push and pop; decides whether another
  // request may be issued back to back.
  assign countAfter = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    reqAddrNext = reqAddr;
    push        = 1'b0;
    flush       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          flush       = 1'b1;
          fetchPcNext = bus.redirect_pc;
        end else if (count < CNT_W'(DEPTH)) begin
          // A free slot exists now and pops only add more, so the
          // response of this request always has room.
          stateNext   = WAIT;
          reqAddrNext = fetchPc;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          flush       = 1'b1;
          fetchPcNext = bus.redirect_pc;
          stateNext   = bus.imem_ready ? IDLE : DRAIN;
        end else if (bus.imem_ready) begin
          push        = 1'b1;
          fetchPcNext = nextPc(reqAddr);
          if (countAfter < (CNT_W+1)'(DEPTH)) begin
            reqAddrNext = nextPc(reqAddr);
          end else begin
            stateNext = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          flush       = 1'b1;
          fetchPcNext = bus.redirect_pc;
        end
        // The stale response retires here even if a new redirect arrives
        // in the same cycle; otherwise the held request would be reissued.
        if (bus.imem_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
    end
  end

  // Address of the outstanding request; only meaningful while imem_req=1.
  always_ff @(posedge clk) begin
    reqAddr <= reqAddrNext;
  end

  assign bus.imem_req        = (state != IDLE);
  assign bus.imem_addr       = reqAddr;
  assign bus.instr_valid     = instrValid;
  assign bus.instr_out       = instrValid ? headData[63:32] : '0;
  assign bus.pc_plus_one_out = instrValid ? headData[31:0]  : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by randomized traffic,
// all cross-checked by a stream-level reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int    DEPTH = 4;
  localparam word_t RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // memory model controls
  int memLat     = 1;
  bit randLat    = 1'b0;
  bit forceReady = 1'b0;
  int pend       = 0;
  int curLat     = 1;
  bit prevAccept = 1'b0;

  // reference model state
  bit    monOn    = 1'b0;
  int    occ      = 0;
  bit    stale    = 1'b0;
  word_t expCons  = RPC;
  word_t expFetch = RPC;
  int    accepts  = 0;
  int    consumed = 0;

  function automatic word_t memWord(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int maxCyc, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.instr_valid && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, word_t'(bus.instr_valid), 32'd1);
  endtask

  task automatic waitReq(input int maxCyc, input bit needNotReady, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.imem_req && !(needNotReady && bus.imem_ready)) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, word_t'(bus.imem_req), 32'd1);
  endtask

  // Instruction memory: answers a request after curLat cycles; data is a
  // fixed function of the address so stale or misplaced words are visible.
  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.imem_req) begin
        if (prevAccept) pend = 0;
        if (pend == 0) curLat = randLat ? int'($urandom_range(1, 4)) : memLat;
        pend++;
        bus.imem_ready = (pend >= curLat);
        bus.imem_rdata = bus.imem_ready ? memWord(bus.imem_addr) : 32'h0;
        prevAccept     = bus.imem_ready;
      end else begin
        pend           = 0;
        prevAccept     = 1'b0;
        bus.imem_ready = forceReady;
        bus.imem_rdata = forceReady ? 32'hDEAD_BEEF : 32'h0;
      end
    end
  end

  // Reference model: the queue is a window onto the address stream that
  // starts at RESET_PC or the last redirect target and counts up by one.
  always @(negedge clk) begin
    if (monOn) begin
      chk("valid_vs_model", word_t'(bus.instr_valid), word_t'(occ > 0));
      if (bus.instr_valid) begin
        chk("head_word_matches_addr", bus.instr_out, memWord(bus.pc_plus_one_out - 32'd1));
      end else begin
        chk("bubble_instr", bus.instr_out, 32'h0);
        chk("bubble_pc", bus.pc_plus_one_out, 32'h0);
      end
      if (bus.imem_req && !stale) begin
        chk("req_addr", bus.imem_addr, expFetch);
        chk("req_has_slot", word_t'(occ < DEPTH), 32'd1);
      end
      if (rst) begin
        occ = 0; stale = 1'b0; expCons = RPC; expFetch = RPC;
      end else if (bus.redirect) begin
        occ = 0;
        if (bus.imem_req) stale = !bus.imem_ready;
        expCons  = bus.redirect_pc;
        expFetch = bus.redirect_pc;
      end else begin
        if (bus.imem_req && bus.imem_ready) begin
          if (stale) stale = 1'b0;
          else begin
            occ++;
            expFetch = expFetch + 32'd1;
            accepts++;
          end
        end
        if (bus.instr_valid && !bus.stall) begin
          chk("consumed_addr", bus.pc_plus_one_out - 32'd1, expCons);
          expCons = expCons + 32'd1;
          occ--;
          consumed++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accStart;
    int consStart;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    memLat = 1;
    tick();
    monOn = 1'b1;
    tick();

    // reset state
    @(negedge clk);
    chk("rst_valid", word_t'(bus.instr_valid), 32'd0);
    chk("rst_req", word_t'(bus.imem_req), 32'd0);
    chk("rst_instr", bus.instr_out, 32'h0);
    chk("rst_pc", bus.pc_plus_one_out, 32'h0);

    // streaming from reset, memory always ready
    tick();
    rst = 1'b0;
    waitValid(3, "first_valid_latency");
    for (int k = 0; k < 4; k++) begin
      chk("stream_pc", bus.pc_plus_one_out, RPC + word_t'(k + 1));
      chk("stream_instr", bus.instr_out, memWord(RPC + word_t'(k)));
      if (k < 3) @(negedge clk);
    end

    // stall holds the head; exactly DEPTH words fetched
    tick();
    rst = 1'b1;
    bus.stall = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    accStart = accepts;
    repeat (10) tick();
    @(negedge clk);
    chk("stall_fetched", word_t'(accepts - accStart), word_t'(DEPTH));
    chk("stall_req_off", word_t'(bus.imem_req), 32'd0);
    chk("stall_valid", word_t'(bus.instr_valid), 32'd1);
    chk("stall_head", bus.pc_plus_one_out, RPC + 32'd1);
    tick();
    bus.stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      waitValid(4, "resume_valid");
      chk("resume_pc", bus.pc_plus_one_out, RPC + word_t'(k + 1));
    end

    // redirect while waiting on a slow memory
    tick();
    rst = 1'b1;
    memLat = 3;
    tick();
    tick();
    rst = 1'b0;
    waitReq(10, 1'b1, "slow_req_seen");
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    waitValid(20, "redir_valid");
    chk("redir_pc", bus.pc_plus_one_out, 32'h41);
    chk("redir_instr", bus.instr_out, memWord(32'h40));

    // redirect coincident with a response while stalled
    tick();
    rst = 1'b1;
    bus.stall = 1'b1;
    memLat = 1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    @(negedge clk);
    chk("coinc_pre_req", word_t'(bus.imem_req), 32'd1);
    chk("coinc_pre_ready", word_t'(bus.imem_ready), 32'd1);
    chk("coinc_pre_valid", word_t'(bus.instr_valid), 32'd1);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("coinc_empty", word_t'(bus.instr_valid), 32'd0);
    waitReq(5, 1'b0, "coinc_req");
    chk("coinc_addr", bus.imem_addr, 32'h40);
    waitValid(5, "coinc_valid");
    chk("coinc_pc", bus.pc_plus_one_out, 32'h41);

    // address wrap
    tick();
    bus.stall = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    waitValid(10, "wrap_valid");
    chk("wrap_pc", bus.pc_plus_one_out, 32'h0);
    chk("wrap_instr", bus.instr_out, memWord(32'hFFFF_FFFF));
    @(negedge clk);
    chk("wrap_next_pc", bus.pc_plus_one_out, 32'h1);

    // reset in the middle of a request, late response afterwards
    tick();
    rst = 1'b1;
    memLat = 3;
    tick();
    tick();
    rst = 1'b0;
    waitReq(10, 1'b1, "midrst_req");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    forceReady = 1'b1;
    @(negedge clk);
    chk("midrst_late_ready", word_t'(bus.imem_ready), 32'd1);
    chk("midrst_no_req", word_t'(bus.imem_req), 32'd0);
    tick();
    forceReady = 1'b0;
    waitValid(20, "midrst_valid");
    chk("midrst_pc", bus.pc_plus_one_out, RPC + 32'd1);
    chk("midrst_instr", bus.instr_out, memWord(RPC));

    // randomized traffic against the model
    tick();
    randLat = 1'b1;
    consStart = consumed;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.stall = ($urandom_range(0, 99) < 30);
      bus.redirect = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0)
        bus.redirect_pc = 32'hFFFF_FFFE - word_t'($urandom_range(0, 2));
      else
        bus.redirect_pc = $urandom;
      rst = ($urandom_range(0, 299) == 0);
    end
    tick();
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("random_progress", word_t'(consumed - consStart > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
